// File: rtl/gray_tracker.sv
// Tracks an asynchronous gray-coded counter: synchronizes it, decodes to binary,
// accepts only single forward steps, and flags/latches illegal transitions.
module gray_tracker #(
    parameter int N    = 3,
    parameter int SYNC = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] gray_in,
    input  logic         en,
    input  logic         clr_err,
    output logic [N-1:0] bin_out,
    output logic         bin_valid,
    output logic         step_err,
    output logic         err_sticky,
    output logic [7:0]   wrap_cnt
);

    // state | meaning
    // IDLE  | not tracking; captures g_s on en
    // TRACK | following single forward steps of g_s
    // ERROR | illegal step seen; waits for clr_err
    typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [SYNC-1:0][N-1:0] sync_q, sync_d;
    logic [N-1:0]           g_p_q, g_p_d;
    logic [N-1:0]           b_p_q, b_p_d;
    logic [N-1:0]           bin_out_q, bin_out_d;
    logic                   bin_valid_q, bin_valid_d;
    logic                   step_err_q, step_err_d;
    logic                   err_sticky_q, err_sticky_d;
    logic [7:0]             wrap_q, wrap_d;

    logic [N-1:0] g_s, dec_s, b_inc, diff;
    logic         one_bit;

    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_comb begin
        sync_d  = {sync_q[SYNC-2:0], gray_in};
        g_s     = sync_q[SYNC-1];
        dec_s   = gray2bin(g_s);
        b_inc   = b_p_q + ONE;
        diff    = g_s ^ g_p_q;
        one_bit = (diff != '0) && ((diff & (diff - ONE)) == '0);
    end

    always_comb begin
        state_d      = state_q;
        g_p_d        = g_p_q;
        b_p_d        = b_p_q;
        bin_out_d    = bin_out_q;
        bin_valid_d  = bin_valid_q;
        step_err_d   = 1'b0;
        err_sticky_d = err_sticky_q;
        wrap_d       = wrap_q;
        case (state_q)
            IDLE: begin
                bin_valid_d = 1'b0;
                if (clr_err) begin
                    err_sticky_d = 1'b0;
                    wrap_d       = 8'd0;
                end
                if (en) begin
                    g_p_d       = g_s;
                    b_p_d       = dec_s;
                    bin_out_d   = dec_s;
                    bin_valid_d = 1'b1;
                    state_d     = TRACK;
                end
            end
            TRACK: begin
                if (clr_err) begin
                    err_sticky_d = 1'b0;
                    wrap_d       = 8'd0;
                end
                if (!en) begin
                    bin_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (diff != '0) begin
                    if (one_bit && (dec_s == b_inc)) begin
                        g_p_d     = g_s;
                        b_p_d     = dec_s;
                        bin_out_d = dec_s;
                        // a pending clear overrides the wrap increment
                        if ((b_p_q == '1) && !clr_err && (wrap_q != 8'hFF)) begin
                            wrap_d = wrap_q + 8'd1;
                        end
                    end else begin
                        step_err_d   = 1'b1;
                        err_sticky_d = 1'b1;
                        bin_valid_d  = 1'b0;
                        state_d      = ERROR;
                    end
                end
            end
            ERROR: begin
                if (clr_err) begin
                    err_sticky_d = 1'b0;
                    wrap_d       = 8'd0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            g_p_q        <= '0;
            b_p_q        <= '0;
            bin_out_q    <= '0;
            bin_valid_q  <= 1'b0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            wrap_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            g_p_q        <= g_p_d;
            b_p_q        <= b_p_d;
            bin_out_q    <= bin_out_d;
            bin_valid_q  <= bin_valid_d;
            step_err_q   <= step_err_d;
            err_sticky_q <= err_sticky_d;
            wrap_q       <= wrap_d;
        end
    end

    assign bin_out    = bin_out_q;
    assign bin_valid  = bin_valid_q;
    assign step_err   = step_err_q;
    assign err_sticky = err_sticky_q;
    assign wrap_cnt   = wrap_q;

endmodule

// File: tb/tb_gray_tracker.sv
// Bench for gray_tracker: a value-level model checked every cycle plus directed
// scenarios with literal expectations.
module tb_gray_tracker;

    localparam int N    = 3;
    localparam int SYNC = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] gray_in = '0;
    logic         en = 1'b0;
    logic         clr_err = 1'b0;
    logic [N-1:0] bin_out;
    logic         bin_valid;
    logic         step_err;
    logic         err_sticky;
    logic [7:0]   wrap_cnt;

    int passed = 0;
    int total  = 0;
    int pulses = 0;

    gray_tracker #(.N(N), .SYNC(SYNC)) dut (
        .clk(clk), .reset(reset), .gray_in(gray_in), .en(en), .clr_err(clr_err),
        .bin_out(bin_out), .bin_valid(bin_valid), .step_err(step_err),
        .err_sticky(err_sticky), .wrap_cnt(wrap_cnt)
    );

    always #5 clk = ~clk;

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & ((1 << N) - 1);
    endfunction

    // gray-to-binary by search: the binary value whose gray code matches
    function automatic int g2b(input int g);
        for (int b = 0; b < (1 << N); b++) if (b2g(b) == g) return b;
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // behavioural model: tracked binary value plus mode flags
    int m_pipe [SYNC];
    int m_bp, m_bout, m_wrap;
    bit m_valid, m_step, m_sticky, m_tracking, m_in_err;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC; i++) m_pipe[i] = 0;
            m_bp = 0; m_bout = 0; m_wrap = 0;
            m_valid = 0; m_step = 0; m_sticky = 0; m_tracking = 0; m_in_err = 0;
        end else begin
            int gs;
            bit wrapped;
            gs = m_pipe[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = int'(gray_in);
            m_step = 0;
            if (m_in_err) begin
                if (clr_err) begin m_in_err = 0; m_sticky = 0; m_wrap = 0; end
            end else if (!m_tracking) begin
                m_valid = 0;
                if (clr_err) begin m_sticky = 0; m_wrap = 0; end
                if (en) begin
                    m_bp = g2b(gs); m_bout = m_bp; m_valid = 1; m_tracking = 1;
                end
            end else if (!en) begin
                if (clr_err) begin m_sticky = 0; m_wrap = 0; end
                m_tracking = 0; m_valid = 0;
            end else if (gs == b2g(m_bp)) begin
                if (clr_err) begin m_sticky = 0; m_wrap = 0; end
            end else if (gs == b2g((m_bp + 1) % (1 << N))) begin
                wrapped = (m_bp == (1 << N) - 1);
                m_bp = (m_bp + 1) % (1 << N);
                m_bout = m_bp;
                if (clr_err) begin m_sticky = 0; m_wrap = 0; end
                else if (wrapped && m_wrap < 255) m_wrap++;
            end else begin
                m_step = 1; m_sticky = 1; m_valid = 0;
                m_in_err = 1; m_tracking = 0;
                if (clr_err) m_wrap = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset) begin
            check("bin_out", int'(bin_out), m_bout);
            check("bin_valid", int'(bin_valid), int'(m_valid));
            check("step_err", int'(step_err), int'(m_step));
            check("err_sticky", int'(err_sticky), int'(m_sticky));
            check("wrap_cnt", int'(wrap_cnt), m_wrap);
            if (step_err) pulses++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int seq [9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
        int p0;

        cyc(3);
        check("rst_bin_out", int'(bin_out), 0);
        check("rst_valid", int'(bin_valid), 0);
        check("rst_wrap", int'(wrap_cnt), 0);
        reset = 1'b1;

        // full forward cycle with one wrap
        en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            gray_in = seq[i][N-1:0];
            cyc(4);
            check("seq_bin", int'(bin_out), i % 8);
            check("seq_valid", int'(bin_valid), 1);
        end
        check("seq_wrap", int'(wrap_cnt), 1);
        check("seq_no_err", pulses, 0);

        // skip 001 -> 010
        gray_in = 3'b001;
        cyc(4);
        check("skip_pre_bin", int'(bin_out), 1);
        gray_in = 3'b010;
        repeat (2) @(posedge clk);
        #1 check("skip_no_early", int'(step_err), 0);
        @(posedge clk);
        #1 check("skip_pulse", int'(step_err), 1);
        @(posedge clk);
        #1 check("skip_pulse_end", int'(step_err), 0);
        @(negedge clk);
        check("skip_sticky", int'(err_sticky), 1);
        check("skip_valid", int'(bin_valid), 0);
        check("skip_bin_hold", int'(bin_out), 1);
        check("skip_one_pulse", pulses, 1);

        // backward step 011 -> 001
        gray_in = 3'b011;
        cyc(3);
        clr_err = 1'b1; cyc(1); clr_err = 1'b0;
        check("bk_clr_sticky", int'(err_sticky), 0);
        check("bk_clr_wrap", int'(wrap_cnt), 0);
        cyc(2);
        check("bk_capture", int'(bin_out), 2);
        check("bk_cap_valid", int'(bin_valid), 1);
        gray_in = 3'b001;
        cyc(4);
        check("bk_sticky", int'(err_sticky), 1);
        check("bk_bin_hold", int'(bin_out), 2);
        check("bk_pulses", pulses, 2);
        clr_err = 1'b1; cyc(1); clr_err = 1'b0;
        check("bk_exit_sticky", int'(err_sticky), 0);
        cyc(2);
        check("bk_recapture", int'(bin_out), 1);
        check("bk_recap_valid", int'(bin_valid), 1);

        // climb to bin 5 with three wraps, then reset between edges
        for (int k = 2; k <= 29; k++) begin
            gray_in = b2g(k % 8);
            cyc(4);
        end
        check("pre_rst_bin", int'(bin_out), 5);
        check("pre_rst_wrap", int'(wrap_cnt), 3);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_bin", int'(bin_out), 0);
        check("mid_rst_valid", int'(bin_valid), 0);
        check("mid_rst_wrap", int'(wrap_cnt), 0);
        check("mid_rst_sticky", int'(err_sticky), 0);
        en = 1'b0;
        gray_in = 3'b110;
        cyc(2);
        reset = 1'b1;
        cyc(3);
        en = 1'b1;
        cyc(2);
        check("post_rst_bin", int'(bin_out), 4);
        check("post_rst_valid", int'(bin_valid), 1);

        // collision of clr_err with a two-bit change, wrap_cnt nonzero first
        for (int k = 5; k <= 8; k++) begin
            gray_in = b2g(k % 8);
            cyc(4);
        end
        check("col_pre_wrap", int'(wrap_cnt), 1);
        p0 = pulses;
        gray_in = 3'b011;
        cyc(2);
        clr_err = 1'b1; cyc(1); clr_err = 1'b0;
        check("col_sticky", int'(err_sticky), 1);
        check("col_wrap", int'(wrap_cnt), 0);
        check("col_valid", int'(bin_valid), 0);
        check("col_pulse", pulses - p0, 1);
        clr_err = 1'b1; cyc(1); clr_err = 1'b0;

        // enable gap while gray advances two steps
        cyc(4);
        check("gap_pre_bin", int'(bin_out), 2);
        p0 = pulses;
        en = 1'b0;
        gray_in = b2g(3);
        cyc(1);
        check("gap_valid0", int'(bin_valid), 0);
        gray_in = b2g(4);
        cyc(2);
        check("gap_valid1", int'(bin_valid), 0);
        en = 1'b1;
        cyc(4);
        check("gap_recapture", int'(bin_out), 4);
        check("gap_valid", int'(bin_valid), 1);
        check("gap_no_err", pulses - p0, 0);

        cyc(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
